// File: rtl/q2a_req_shaper.sv
// Burst-command to level-request shaper feeding a 3-way priority arbiter (1>2>3).
// Optional per-channel wait timeout is enabled by defining Q2A_WAIT_TIMEOUT_EN.
module q2a_req_shaper #(
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:1]       req_pulse,
  input  logic [3*LEN_W-1:0] req_len,
  input  logic [3:1]       g,
  output logic [3:1]       r,
  output logic [3:1]       done,
  output logic [3:1]       ovf,
  output logic             proto_err,
  output logic [3:1]       timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [3:1][1:0]       st_q, st_d;
  logic [3:1][LEN_W-1:0] cnt_q, cnt_d;
  logic [3:1]            r_q, r_d;
  logic [3:1]            done_q, done_d;
  logic [3:1]            ovf_q, ovf_d;
  logic [3:1]            tmo_q, tmo_d;
  logic                  perr_q, perr_d;
  logic [3:1]            beat;
  logic [3:1]            lag;
  logic [LEN_W-1:0]      len_f;

`ifdef Q2A_WAIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [3:1][WAIT_W-1:0] wcnt_q, wcnt_d;
`else
  localparam int unused_max_wait = MAX_WAIT;
`endif

  assign beat = g & r_q;
  // r fell on the previous edge: the registered arbiter may still show g for one cycle
  assign lag  = done_q | tmo_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    r_d    = r_q;
    done_d = '0;
    ovf_d  = '0;
    tmo_d  = '0;
    perr_d = perr_q;
    len_f  = '0;
`ifdef Q2A_WAIT_TIMEOUT_EN
    wcnt_d = '0;
`endif
    if ((g & (g - 3'd1)) != 3'b000)
      perr_d = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      len_f = req_len[i*LEN_W-1 -: LEN_W];
      if (g[i] && st_q[i] == S_IDLE && !lag[i])
        perr_d = 1'b1;
      case (st_q[i])
        S_IDLE: begin
          if (req_pulse[i]) begin
            if (lag[i]) begin
              ovf_d[i] = 1'b1;
            end else begin
              st_d[i]  = S_WAIT;
              cnt_d[i] = (len_f == '0) ? LEN_W'(1) : len_f;
              r_d[i]   = 1'b1;
            end
          end
        end
        S_WAIT, S_XFER: begin
          if (req_pulse[i])
            ovf_d[i] = 1'b1;
          if (beat[i]) begin
            if (cnt_q[i] == LEN_W'(1)) begin
              done_d[i] = 1'b1;
              r_d[i]    = 1'b0;
              st_d[i]   = S_IDLE;
              cnt_d[i]  = '0;
            end else begin
              cnt_d[i]  = cnt_q[i] - LEN_W'(1);
              st_d[i]   = S_XFER;
            end
          end else if (st_q[i] == S_XFER) begin
            st_d[i] = S_WAIT;
          end
`ifdef Q2A_WAIT_TIMEOUT_EN
          else if (wcnt_q[i] == WAIT_W'(MAX_WAIT - 1)) begin
            tmo_d[i] = 1'b1;
            r_d[i]   = 1'b0;
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end else begin
            wcnt_d[i] = wcnt_q[i] + WAIT_W'(1);
          end
`endif
        end
        default: begin
          st_d[i] = S_IDLE;
          r_d[i]  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= '0;
      cnt_q  <= '0;
      r_q    <= '0;
      done_q <= '0;
      ovf_q  <= '0;
      tmo_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      tmo_q  <= tmo_d;
      perr_q <= perr_d;
    end
  end

`ifdef Q2A_WAIT_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end
  assign timeout = tmo_q;
`else
  assign timeout = 3'b000;
`endif

  assign r         = r_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_q2a_req_shaper.sv
// Scoreboard bench for q2a_req_shaper with a registered priority-arbiter model.
module tb_q2a_req_shaper;
  localparam int LEN_W    = 7;
  localparam int MAX_WAIT = 64;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [3:1]         req_pulse = '0;
  logic [3*LEN_W-1:0] req_len = '0;
  logic [3:1]         g;
  logic [3:1]         r, done, ovf, timeout;
  logic               proto_err;

  logic [3:1] arb_q;
  logic       force_en = 1'b0;
  logic [3:1] force_g = '0;

  typedef struct { int ch; int beats; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_bad = 0;
  int bcnt[1:3];
  int ovf_cnt[1:3];
  int tmo_cnt[1:3];
  int cyc = 0;
  int r3_rise = -1;
  int tmo3_cyc = -1;

  q2a_req_shaper #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .req_pulse(req_pulse), .req_len(req_len),
    .g(g), .r(r), .done(done), .ovf(ovf), .proto_err(proto_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Arbiter: keeps the current grant while its request is high, else picks by priority.
  function automatic logic [3:1] arb_nxt(input logic [3:1] rr, input logic [3:1] cur);
    if ((cur & rr) != 3'b000) return cur;
    if (rr[1]) return 3'b001;
    if (rr[2]) return 3'b010;
    if (rr[3]) return 3'b100;
    return 3'b000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) arb_q <= '0;
    else       arb_q <= arb_nxt(r, arb_q);
  end

  assign g = force_en ? force_g : arb_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (r[3] && r3_rise < 0) r3_rise = cyc;
      for (int i = 1; i <= 3; i++) begin
        if (done[i]) begin
          chk("done_r_low", {31'd0, r[i]}, 32'd0);
          if (sb.size() == 0) begin
            chk("done_unexpected", i, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_ch", i, e.ch);
            chk("done_beats", bcnt[i], e.beats);
          end
          bcnt[i] = 0;
        end
        if (ovf[i]) ovf_cnt[i]++;
        if (timeout[i]) begin
          tmo_cnt[i]++;
          bcnt[i] = 0;
          if (i == 3) tmo3_cyc = cyc;
        end
        if (g[i] && r[i]) bcnt[i]++;
      end
    end
  end

  task automatic clear_mon();
    sb.delete();
    for (int i = 1; i <= 3; i++) begin
      bcnt[i] = 0; ovf_cnt[i] = 0; tmo_cnt[i] = 0;
    end
  endtask

  task automatic send(input logic [3:1] p, input int l1, input int l2, input int l3);
    int lens[1:3];
    exp_t e;
    lens[1] = l1; lens[2] = l2; lens[3] = l3;
    @(posedge clk); #1;
    req_pulse = p;
    req_len = {LEN_W'(l3), LEN_W'(l2), LEN_W'(l1)};
    for (int i = 1; i <= 3; i++)
      if (p[i]) begin
        e.ch = i;
        e.beats = (lens[i] == 0) ? 1 : lens[i];
        sb.push_back(e);
      end
    @(posedge clk); #1;
    req_pulse = '0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (r == 3'b000 && sb.size() == 0) begin ok = 1; break; end
    end
    chk("wait_idle", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int ch, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done[ch]) begin ok = 1; break; end
    end
    chk("wait_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    reset = 1'b0;
  endtask

  initial begin
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_r", r, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_ovf", ovf, 3'b000);
    chk("rst_perr", proto_err, 1'b0);
    chk("rst_tmo", timeout, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 3'b000);
    chk("post_rst_ovf", ovf, 3'b000);

    // Test 2: single burst, latency of r vs g
    send(3'b001, 3, 0, 0);
    @(negedge clk);
    chk("t2_r_first", r, 3'b001);
    chk("t2_g_first", g, 3'b000);
    @(negedge clk);
    chk("t2_g_next", g, 3'b001);
    wait_idle(50);
    chk("t2_r_after", r, 3'b000);

    // Test 3: all three at once, serviced in priority order
    send(3'b111, 2, 1, 4);
    wait_idle(100);
    chk("t3_perr", proto_err, 1'b0);

    // Test 4: zero length is one beat; pulse in done cycle is ovf
    send(3'b001, 0, 0, 0);
    wait_done(1, 20);
    req_pulse = 3'b001;
    req_len = {LEN_W'(0), LEN_W'(0), LEN_W'(5)};
    @(posedge clk); #1;
    req_pulse = '0;
    @(negedge clk);
    chk("t4_ovf", ovf, 3'b001);
    chk("t4_no_new_r", r, 3'b000);
    wait_idle(20);
    chk("t4_ovf_cnt", ovf_cnt[1], 1);
    // Pulse in the cycle right after done is accepted
    send(3'b010, 2, 2, 0);
    wait_done(2, 20);
    send(3'b010, 0, 3, 0);
    wait_idle(50);
    chk("t4b_ovf_cnt", ovf_cnt[2], 0);
    chk("t4_perr", proto_err, 1'b0);

    // Test 1: async reset mid-burst
    send(3'b001, 5, 0, 0);
    repeat (3) @(negedge clk);
    chk("t1_busy", r, 3'b001);
    #2 reset = 1'b1;
    #1;
    chk("t1_r_async", r, 3'b000);
    chk("t1_done", done, 3'b000);
    chk("t1_ovf", ovf, 3'b000);
    @(negedge clk);
    clear_mon();
    reset = 1'b0;
    @(negedge clk);
    chk("t1_r_released", r, 3'b000);
    chk("t1_done_rel", done, 3'b000);
    send(3'b001, 2, 0, 0);
    wait_idle(30);

    // Test 5: multi-hot grant sets sticky proto_err
    @(posedge clk); #1;
    force_en = 1'b1; force_g = 3'b011;
    @(posedge clk); #1;
    force_en = 1'b0; force_g = 3'b000;
    @(negedge clk);
    chk("t5_perr_set", proto_err, 1'b1);
    repeat (5) @(negedge clk);
    chk("t5_perr_sticky", proto_err, 1'b1);
    do_reset();
    @(negedge clk);
    chk("t5_perr_clr", proto_err, 1'b0);
    // Grant to an idle channel is also a violation
    @(posedge clk); #1;
    force_en = 1'b1; force_g = 3'b010;
    @(posedge clk); #1;
    force_en = 1'b0; force_g = 3'b000;
    @(negedge clk);
    chk("t5b_perr_idle", proto_err, 1'b1);
    do_reset();

    // Test 6: ch3 waits behind a long ch1 burst
    r3_rise = -1; tmo3_cyc = -1;
    send(3'b001, 80, 0, 0);
    @(negedge clk);
    send(3'b100, 0, 0, 2);
`ifdef Q2A_WAIT_TIMEOUT_EN
    void'(sb.pop_back());
    wait_idle(300);
    chk("t6_tmo3", tmo_cnt[3], 1);
    chk("t6_tmo_at", tmo3_cyc - r3_rise, MAX_WAIT);
`else
    wait_idle(300);
    chk("t6_tmo3", tmo_cnt[3], 0);
`endif
    chk("t6_tmo1", tmo_cnt[1], 0);
    chk("t6_perr", proto_err, 1'b0);
    chk("end_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
